// File: rtl/feature_aggregator_if.sv
// feature_aggregator_if: serial feature input and aggregated vector output handshakes.
interface feature_aggregator_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int ACC_W = 16
);
   logic [WIDTH-1:0]       in_data;
   logic                   in_valid;
   logic                   in_ready;
   logic [ACC_W*DEPTH-1:0] out_data;
   logic                   out_valid;
   logic                   out_ready;
   modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
   modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/feature_aggregator.sv
// feature_aggregator: element-wise sum of num_nbr serial feature vectors into one parallel word.
// AGG_SATURATE_EN selects saturating accumulation and adds the sticky sat_flag output.
module feature_aggregator #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int ACC_W = 16,
   parameter int NBR_W = 8
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             start,
   input  logic [NBR_W-1:0] num_nbr,
   feature_aggregator_if.slave bus,
`ifdef AGG_SATURATE_EN
   output logic             sat_flag,
`endif
   output logic             busy
);
   localparam int FI_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
   state_t state, next_state;
   logic signed [ACC_W-1:0] acc [DEPTH];
   logic [FI_W-1:0] feat_idx;
   logic [NBR_W-1:0] nbr_cnt, nbr_lat;
   logic signed [ACC_W-1:0] ext, acc_cur, acc_next;
   logic xfer, wrap, last;
   assign xfer = state == ACCUM && bus.in_valid;
   assign wrap = feat_idx == FI_W'(DEPTH - 1);
   assign last = xfer && wrap && nbr_cnt == nbr_lat - NBR_W'(1);
   assign ext = ACC_W'(signed'(bus.in_data));
   assign acc_cur = acc[feat_idx];
`ifdef AGG_SATURATE_EN
   logic signed [ACC_W:0] sum;
   logic clamp;
   assign sum = {acc_cur[ACC_W-1], acc_cur} + {ext[ACC_W-1], ext};
   // the two top bits of the widened sum disagree exactly on signed overflow
   assign clamp = sum[ACC_W] != sum[ACC_W-1];
   assign acc_next = clamp ? (sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                           : sum[ACC_W-1:0];
`else
   assign acc_next = acc_cur + ext;
`endif
   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) state <= IDLE;
      else state <= next_state;
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = start ? (num_nbr == '0 ? DONE : ACCUM) : IDLE;
         ACCUM:   next_state = last ? DONE : ACCUM;
         DONE:    next_state = bus.out_ready ? IDLE : DONE;
         default: next_state = IDLE;
      endcase
   end
   always_comb begin
      bus.in_ready  = state == ACCUM;
      bus.out_valid = state == DONE;
      busy          = state != IDLE;
   end
   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) begin
         for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
         feat_idx <= '0;
         nbr_cnt  <= '0;
         nbr_lat  <= '0;
`ifdef AGG_SATURATE_EN
         sat_flag <= 1'b0;
`endif
      end else if (state == IDLE && start) begin
         for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
         feat_idx <= '0;
         nbr_cnt  <= '0;
         nbr_lat  <= num_nbr;
`ifdef AGG_SATURATE_EN
         sat_flag <= 1'b0;
`endif
      end else if (xfer) begin
         acc[feat_idx] <= acc_next;
         feat_idx      <= wrap ? '0 : feat_idx + FI_W'(1);
         nbr_cnt       <= wrap ? nbr_cnt + NBR_W'(1) : nbr_cnt;
`ifdef AGG_SATURATE_EN
         sat_flag      <= sat_flag | clamp;
`endif
      end
   // feature 0 lands in the most significant slice
   for (genvar i = 0; i < DEPTH; i++) begin : g_out
      assign bus.out_data[ACC_W*(DEPTH-i)-1 -: ACC_W] = acc[i];
   end
endmodule

// File: doc/feature_aggregator.md
# feature_aggregator

- Sits directly downstream of the parallel-in/serial-out feature buffer.
- Consumes a serial stream of WIDTH-bit signed feature words, DEPTH words per neighbour vector.
- Sums element-wise over a programmed number of neighbour vectors and presents the aggregated vector as one parallel word.
- Handshake: in_ready drives the buffer's read enable; in_valid comes from the buffer's not-empty flag.

## Interface
- WIDTH, 8, bits per input feature word (two's complement)
- DEPTH, 16, features per vector
- ACC_W, 16, accumulator width per feature (ACC_W >= WIDTH)
- NBR_W, 8, width of the neighbour-count input
- clk  in  1  clock; all logic on rising edge
- arst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins an aggregation (sampled in IDLE only)
- num_nbr  in  NBR_W  number of neighbour vectors to sum (unsigned), sampled with start
- in_data  in  WIDTH  current feature word, valid in the same cycle as in_valid && in_ready
- in_valid  in  1  upstream has a word available
- in_ready  out  1  block accepts a word this cycle (feeds upstream read enable)
- out_data  out  ACC_W*DEPTH  aggregated vector; feature 0 in the most significant slice
- out_valid  out  1  out_data valid; held until out_ready
- out_ready  in  1  downstream accepts out_data
- busy  out  1  high in ACCUM or DONE

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start, clear all DEPTH accumulators, zero feat_idx and nbr_cnt, and latch num_nbr.
  - If num_nbr==0, go to DONE (all-zero vector); otherwise go to ACCUM.
- ACCUM:
  - in_ready=1.
  - Transfer happens when in_valid && in_ready; then acc[feat_idx] <= acc[feat_idx] + sign_extend(in_data).
  - feat_idx increments, wrapping at DEPTH-1 to 0; each wrap increments nbr_cnt.
  - The transfer with feat_idx==DEPTH-1 and nbr_cnt==latched_num_nbr-1 is the last; go to DONE.
  - No transfer leaves all state unchanged.
- DONE:
  - in_ready=0, out_valid=1, out_data = concatenation of acc[0..DEPTH-1].
  - On out_ready, go to IDLE; accumulators keep their value until the next start.
- start while in ACCUM or DONE is ignored. num_nbr changes outside the start cycle are ignored.
- Counter widths: feat_idx is $clog2(DEPTH) bits; nbr_cnt is NBR_W bits.
- Arithmetic: signed, ACC_W bits. Overflow behaviour is set by the configuration macro.
- Reset mid-operation discards the partial sums: state IDLE, all accumulators 0, counters 0.

## Timing
- Reset values: in_ready=0, out_valid=0, busy=0, out_data=0.
- start at cycle T: busy=1 and in_ready=1 (or out_valid=1 when num_nbr==0) from T+1.
- Throughput: one word per cycle while in_valid stays high.
- out_valid asserts in the cycle after the last accepted word. A minimal run of N*DEPTH words completes in N*DEPTH+1 cycles after start.
- in_ready is a registered state decode; it has no combinational path from in_valid.
- out_valid && out_ready at cycle T: out_valid=0 and busy=0 at T+1. A start at T+1 is accepted.
- in_data is sampled only on transfer cycles. Upstream drives 0 when not read, which is harmless.

## Configuration
- AGG_SATURATE_EN defined:
  - Each accumulate saturates to the signed ACC_W range, max 2^(ACC_W-1)-1 and min -2^(ACC_W-1).
  - A sticky status bit sat_flag (extra output, 1 bit) sets on any clamp and clears on start.
- AGG_SATURATE_EN undefined: the accumulate wraps modulo 2^ACC_W; no sat_flag port.

## Test plan
- Default parameters, start with num_nbr=2, in_valid held high:
  - Stream 32 words; vector A is feature i = i, vector B is feature i = -1.
  - Required: out_data feature i = i-1; out_valid at cycle 33 after start.
- num_nbr=3, in_valid toggling 1/0 every cycle:
  - Stream 48 words of value 5. Required: each feature = 15; in_ready=1 throughout ACCUM; no word counted twice.
- start with num_nbr=0:
  - Required: out_valid at T+1 with out_data all zero; in_ready never asserts.
- out_ready held low for 10 cycles in DONE, with start pulsed during that time:
  - Required: out_data stable, start ignored, IDLE one cycle after out_ready=1.
- ACC_W=8, num_nbr=3, all words 127:
  - With AGG_SATURATE_EN: each feature = 127 and sat_flag=1.
  - Without it: each feature = 125 (381 mod 256).
- arst_n pulled low after 20 accepted words:
  - Required: in_ready=0, busy=0, out_valid=0 immediately.
  - A fresh start with num_nbr=1 then yields exactly the new vector.
